stage_burn_responder: RTL and testbench
=======================================

// Module: stage_burn_responder
// PURPOSE
// Responder side of the stage-sequencing handshake: accepts one stage's burn parameters, runs the burn, and returns
// per-second vehicle state. It raises ignition_end when the burn finishes so the stage sequencer can load the next stage.
// Models vertical flight: per-second net acceleration is thrust/mass - g, integrated into velocity.
// Sits between the stage sequencer (upstream) and the height integrator/gimbal blocks (downstream).
// PARAMETERS
// N            64      datapath width; all ports and internal arithmetic are unsigned
// GRAVITY      9_799   g0 in mm/s^2; used in both the thrust term and the gravity term
// TICK_CYCLES  100     clk cycles per simulated second; must be >= N+2 (elaboration-time $error otherwise)
// PORTS
// clk               in   1  clock
// reset             in   1  synchronous, active-high reset
// load_valid        in   1  stage parameters valid
// load_ready        out  1  responder idle and able to accept a load
// specificImpulse   in   N  Isp in s
// initialWeight     in   N  vehicle mass at ignition, kg
// propellantWeight  in   N  propellant burned this stage, kg
// burntime          in   N  burn duration, whole seconds
// velocity          out  N  cumulative vertical velocity, mm/s
// currentWeight     out  N  vehicle mass, kg
// burnSecond        out  N  seconds elapsed in current burn
// busy              out  1  burn in progress (state != IDLE)
// ignition_end      out  1  one-cycle pulse: burn complete
// param_error       out  1  one-cycle pulse: load rejected
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-high.
// - Reset: state=IDLE; velocity=0, currentWeight=0, burnSecond=0, busy=0, ignition_end=0, param_error=0.
//   load_ready=1 from the first cycle after reset deasserts.
// - Reset mid-burn: the divider aborts and every register clears the same cycle; no ignition_end is issued.
// - FSM states: IDLE -> DIV_MDOT -> BURN -> DIV_ACCEL -> ACCUM -> (BURN | DONE) -> IDLE.
// - IDLE: load_ready=1. On load_valid&load_ready (cycle C), capture all four inputs and set currentWeight=initialWeight.
//   burnSecond=0. velocity is NOT cleared; it carries across stages.
// - Reject a load if burntime==0 or propellantWeight>=initialWeight: pulse param_error at C+1, remain in IDLE,
//   leave all outputs unchanged.
// - load_valid while busy is ignored (load_ready=0).
// - DIV_MDOT: mdot = propellantWeight/burntime, shared restoring divider, 1 quotient bit/cycle, N cycles (C+1..C+N).
//   rem = remainder.
// - BURN: tick counter runs 0..TICK_CYCLES-1 and wraps; it starts at 0 on entry from DIV_MDOT.
//   At count TICK_CYCLES-1 -> DIV_ACCEL. The counter keeps running through DIV_ACCEL/ACCUM, so ticks never drift.
// - DIV_ACCEL: accel = (specificImpulse*GRAVITY*mdot)/currentWeight.
//   Product truncated to N bits; uses the mass at the start of the second. N cycles.
// - ACCUM (1 cycle): if accel>=GRAVITY, velocity += accel-GRAVITY; else velocity -= GRAVITY-accel, saturating at 0.
//   Also in ACCUM: burnSecond += 1.
//   currentWeight -= mdot, or mdot+rem when burnSecond was burntime-1, so exactly propellantWeight is consumed.
//   All three outputs update together here, once per tick.
// - After the ACCUM where burnSecond becomes burntime -> DONE: ignition_end=1 for exactly one cycle, busy still 1.
//   Next cycle -> IDLE: busy=0, load_ready=1.
// - A load presented in the ignition_end cycle is not accepted; the earliest accept is the following cycle.
// - currentWeight==0 cannot occur (guarded by the reject rule); no divide-by-zero path.
// TESTING
// - Basic burn: Isp=100, initW=1000, prop=500, burntime=5.
//   -> mdot=100; tick1 velocity=88191, weight=900; tick2 velocity=187269, weight=800.
//   -> ignition_end after tick5, weight=500.
// - Saturn stage 1: Isp=263, initW=2875403, prop=2077000, bt=168.
//   -> mdot=12363 rem 16; tick1 velocity=1281, weight=2863040.
//   -> final weight 798403; ignition_end exactly once.
// - Tick timing: updates spaced exactly TICK_CYCLES cycles apart.
//   -> first update at C+N+TICK_CYCLES+N+1; busy falls 1 cycle after ignition_end.
// - Reject: burntime=0, or prop=1000 with initW=1000.
//   -> param_error pulse at C+1, load_ready stays 1, no ignition_end, outputs unchanged.
// - Gravity clamp: velocity=0, Isp=1, initW=1000, prop=10, bt=10.
//   -> accel=9 < GRAVITY; velocity stays 0 all 10 ticks.
//   -> Back-to-back second stage keeps the prior velocity.
// - Reset at tick 3 of a burn -> all outputs 0 next cycle, no ignition_end; a fresh load afterwards behaves as from cold start.

Source files
------------

// File: rtl/stage_burn_responder.sv
// -----------------------------------------------------------------------------
// stage_burn_responder
//
// Purpose:
//   Responder half of the stage-sequencing handshake. Accepts one stage's burn
//   parameters, then once per simulated second integrates the vertical velocity.
//   Net acceleration is thrust/mass - g. It burns propellant at a constant mass
//   flow and pulses ignition_end when the stage is spent.
//
// Ports:
//   clk              clock
//   reset            synchronous, active-high reset
//   load_valid       stage parameters valid
//   load_ready       idle and able to accept a load
//   specificImpulse  Isp, seconds
//   initialWeight    mass at ignition, kg
//   propellantWeight propellant burned this stage, kg
//   burntime         burn duration, whole seconds
//   velocity         cumulative vertical velocity, mm/s (carries across stages)
//   currentWeight    vehicle mass, kg
//   burnSecond       seconds elapsed in the current burn
//   busy             burn in progress
//   ignition_end     one-cycle pulse when the burn is complete
//   param_error      one-cycle pulse when a load is rejected
// -----------------------------------------------------------------------------
module stage_burn_responder #(
    parameter int N           = 64,
    parameter int GRAVITY     = 9_799,
    parameter int TICK_CYCLES = 100
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [N-1:0] specificImpulse,
    input  logic [N-1:0] initialWeight,
    input  logic [N-1:0] propellantWeight,
    input  logic [N-1:0] burntime,
    output logic [N-1:0] velocity,
    output logic [N-1:0] currentWeight,
    output logic [N-1:0] burnSecond,
    output logic         busy,
    output logic         ignition_end,
    output logic         param_error
);

    // The acceleration divide and the ACCUM cycle must both fit inside one tick.
    if (TICK_CYCLES < N + 2) begin : g_tick_check
        $error("stage_burn_responder: TICK_CYCLES must be >= N+2");
    end

    localparam int          TW     = $clog2(TICK_CYCLES);
    localparam int          CW     = $clog2(N);
    localparam logic [N-1:0] GRAV_N = N'(GRAVITY);
    localparam logic [N-1:0] ONE_N  = N'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIV_MDOT,
        S_BURN,
        S_DIV_ACCEL,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [N-1:0]  isp_reg;
    logic [N-1:0]  burntime_reg;
    logic [N-1:0]  mdot_reg;
    logic [N-1:0]  mdot_rem_reg;
    logic [N-1:0]  accel_reg;
    logic [N-1:0]  velocity_reg;
    logic [N-1:0]  weight_reg;
    logic [N-1:0]  burn_sec_reg;
    logic          param_error_reg;
    logic [TW-1:0] tick_reg;

    // Shared restoring divider: quotient bits shift in from the right while
    // the dividend shifts out of the top of the same register.
    logic [N-1:0]  div_quo_reg;
    logic [N-1:0]  div_rem_reg;
    logic [N-1:0]  div_den_reg;
    logic [CW-1:0] div_cnt_reg;

    logic [N:0]    div_trial;
    logic [N:0]    div_diff;
    logic          div_ge;
    logic [N-1:0]  div_quo_step;
    logic [N-1:0]  div_rem_step;

    assign div_trial    = {div_rem_reg, div_quo_reg[N-1]};
    assign div_diff     = div_trial - {1'b0, div_den_reg};
    assign div_ge       = (div_trial >= {1'b0, div_den_reg});
    assign div_quo_step = {div_quo_reg[N-2:0], div_ge};
    assign div_rem_step = div_ge ? div_diff[N-1:0] : div_trial[N-1:0];

    logic         accept;
    logic         params_bad;
    logic         div_last;
    logic         tick_last;
    logic         final_sec;
    logic [N-1:0] thrust_num;
    logic [N-1:0] grav_deficit;

    assign accept       = load_valid && (state_reg == S_IDLE);
    assign params_bad   = (burntime == '0) || (propellantWeight >= initialWeight);
    assign div_last     = (div_cnt_reg == CW'(N - 1));
    assign tick_last    = (tick_reg == TW'(TICK_CYCLES - 1));
    assign final_sec    = (burn_sec_reg == burntime_reg - ONE_N);
    // Isp*g0*mdot, deliberately truncated to the datapath width.
    assign thrust_num   = isp_reg * GRAV_N * mdot_reg;
    assign grav_deficit = GRAV_N - accel_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:      if (accept && !params_bad) state_next = S_DIV_MDOT;
            S_DIV_MDOT:  if (div_last)  state_next = S_BURN;
            S_BURN:      if (tick_last) state_next = S_DIV_ACCEL;
            S_DIV_ACCEL: if (div_last)  state_next = S_ACCUM;
            S_ACCUM:     state_next = final_sec ? S_DONE : S_BURN;
            S_DONE:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            isp_reg         <= '0;
            burntime_reg    <= '0;
            mdot_reg        <= '0;
            mdot_rem_reg    <= '0;
            accel_reg       <= '0;
            velocity_reg    <= '0;
            weight_reg      <= '0;
            burn_sec_reg    <= '0;
            param_error_reg <= 1'b0;
            tick_reg        <= '0;
            div_quo_reg     <= '0;
            div_rem_reg     <= '0;
            div_den_reg     <= '0;
            div_cnt_reg     <= '0;
        end else begin
            param_error_reg <= 1'b0;

            // Load: start mdot = propellantWeight / burntime. Velocity is kept.
            if (accept) begin
                if (params_bad) begin
                    param_error_reg <= 1'b1;
                end else begin
                    isp_reg      <= specificImpulse;
                    burntime_reg <= burntime;
                    weight_reg   <= initialWeight;
                    burn_sec_reg <= '0;
                    div_quo_reg  <= propellantWeight;
                    div_rem_reg  <= '0;
                    div_den_reg  <= burntime;
                    div_cnt_reg  <= '0;
                end
            end

            if (state_reg == S_DIV_MDOT || state_reg == S_DIV_ACCEL) begin
                div_quo_reg <= div_quo_step;
                div_rem_reg <= div_rem_step;
                div_cnt_reg <= div_cnt_reg + CW'(1);
            end

            if (state_reg == S_DIV_MDOT && div_last) begin
                mdot_reg     <= div_quo_step;
                mdot_rem_reg <= div_rem_step;
                tick_reg     <= '0;
            end

            // The tick counter free-runs for the whole burn so ticks never drift.
            if (state_reg == S_BURN || state_reg == S_DIV_ACCEL || state_reg == S_ACCUM) begin
                tick_reg <= tick_last ? '0 : tick_reg + TW'(1);
            end

            // Start of a new second: divide by the mass at the start of it.
            if (state_reg == S_BURN && tick_last) begin
                div_quo_reg <= thrust_num;
                div_rem_reg <= '0;
                div_den_reg <= weight_reg;
                div_cnt_reg <= '0;
            end

            if (state_reg == S_DIV_ACCEL && div_last) begin
                accel_reg <= div_quo_step;
            end

            if (state_reg == S_ACCUM) begin
                if (accel_reg >= GRAV_N) begin
                    velocity_reg <= velocity_reg + (accel_reg - GRAV_N);
                end else if (velocity_reg >= grav_deficit) begin
                    velocity_reg <= velocity_reg - grav_deficit;
                end else begin
                    velocity_reg <= '0;
                end
                burn_sec_reg <= burn_sec_reg + ONE_N;
                // The division remainder is burned in the last second so the
                // stage consumes exactly its propellant mass.
                weight_reg   <= final_sec ? weight_reg - (mdot_reg + mdot_rem_reg)
                                          : weight_reg - mdot_reg;
            end
        end
    end

    assign load_ready    = (state_reg == S_IDLE);
    assign busy          = (state_reg != S_IDLE);
    assign ignition_end  = (state_reg == S_DONE);
    assign param_error   = param_error_reg;
    assign velocity      = velocity_reg;
    assign currentWeight = weight_reg;
    assign burnSecond    = burn_sec_reg;

endmodule

// File: tb/tb_stage_burn_responder.sv
module tb_stage_burn_responder;

    localparam int N  = 64;
    localparam int T  = 100;
    localparam int NV = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_valid;
    logic         load_ready;
    logic [N-1:0] specificImpulse;
    logic [N-1:0] initialWeight;
    logic [N-1:0] propellantWeight;
    logic [N-1:0] burntime;
    logic [N-1:0] velocity;
    logic [N-1:0] currentWeight;
    logic [N-1:0] burnSecond;
    logic         busy;
    logic         ignition_end;
    logic         param_error;

    always #5 clk = ~clk;

    stage_burn_responder #(.N(N), .GRAVITY(9_799), .TICK_CYCLES(T)) dut (
        .clk              (clk),
        .reset            (reset),
        .load_valid       (load_valid),
        .load_ready       (load_ready),
        .specificImpulse  (specificImpulse),
        .initialWeight    (initialWeight),
        .propellantWeight (propellantWeight),
        .burntime         (burntime),
        .velocity         (velocity),
        .currentWeight    (currentWeight),
        .burnSecond       (burnSecond),
        .busy             (busy),
        .ignition_end     (ignition_end),
        .param_error      (param_error)
    );

    typedef struct {
        logic [63:0] isp;
        logic [63:0] initw;
        logic [63:0] prop;
        logic [63:0] bt;
        bit          reject;
        logic [63:0] v1;
        logic [63:0] w1;
        bit          chk_vf;
        logic [63:0] vf;
        logic [63:0] wf;
    } vec_t;

    vec_t tbl [NV];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_vec(input int i);
        specificImpulse  = tbl[i].isp;
        initialWeight    = tbl[i].initw;
        propellantWeight = tbl[i].prop;
        burntime         = tbl[i].bt;
        load_valid       = 1'b1;
    endtask

    task automatic run_vec(input int i);
        logic [63:0] v0, w0;
        int e, g, bad_gap, early;
        v0 = velocity;
        w0 = currentWeight;
        drive_vec(i);
        tick();
        load_valid = 1'b0;
        if (tbl[i].reject) begin
            chk("rej_perr", param_error, 1);
            chk("rej_ready", load_ready, 1);
            chk("rej_busy", busy, 0);
            chk("rej_ign", ignition_end, 0);
            chk("rej_vel", velocity, v0);
            chk("rej_wt", currentWeight, w0);
            tick();
            chk("rej_perr_pulse", param_error, 0);
            $display("vec %0d: rejected load, velocity=%0d weight=%0d", i, velocity, currentWeight);
            return;
        end
        chk("acc_busy", busy, 1);
        chk("acc_ready", load_ready, 0);
        chk("acc_perr", param_error, 0);
        chk("acc_wt", currentWeight, tbl[i].initw);
        chk("acc_sec", burnSecond, 0);
        chk("acc_vel_kept", velocity, v0);
        e = 0;
        while (burnSecond != 1 && e < 2*N + T + 20) begin
            tick();
            e++;
        end
        chk("first_update_cycle", e, 2*N + T + 1);
        chk("tick1_vel", velocity, tbl[i].v1);
        chk("tick1_wt", currentWeight, tbl[i].w1);
        bad_gap = 0;
        early   = 0;
        for (int t = 2; t <= int'(tbl[i].bt); t++) begin
            g = 0;
            while (burnSecond != t && g < T + 5) begin
                if (ignition_end) early++;
                tick();
                g++;
            end
            if (g != T) bad_gap++;
        end
        chk("tick_gaps", bad_gap, 0);
        chk("ign_early", early, 0);
        chk("ign_end", ignition_end, 1);
        chk("done_busy", busy, 1);
        chk("final_sec", burnSecond, tbl[i].bt);
        chk("final_wt", currentWeight, tbl[i].wf);
        if (tbl[i].chk_vf) chk("final_vel", velocity, tbl[i].vf);
        // Present the next load in the ignition_end cycle; it must wait a cycle.
        if (i + 1 < NV && i + 1 != 5) drive_vec(i + 1);
        tick();
        chk("ign_pulse", ignition_end, 0);
        chk("idle_busy", busy, 0);
        chk("idle_ready", load_ready, 1);
        $display("vec %0d: burn done secs=%0d velocity=%0d weight=%0d", i, burnSecond, velocity, currentWeight);
    endtask

    initial begin
        //        isp  initw    prop     bt   rej v1      w1       chkvf vf      wf
        tbl[0] = '{1,   1000,    10,      10,  0,  0,      999,     1,    0,      990};
        tbl[1] = '{100, 1000,    500,     5,   0,  88191,  900,     1,    583660, 500};
        tbl[2] = '{1,   1000,    10,      10,  0,  573870, 999,     1,    485760, 990};
        tbl[3] = '{100, 1000,    500,     0,   1,  0,      0,       0,    0,      0};
        tbl[4] = '{100, 1000,    1000,    5,   1,  0,      0,       0,    0,      0};
        tbl[5] = '{263, 2875403, 2077000, 168, 0,  1281,   2863040, 0,    0,      798403};

        reset = 1'b1;
        load_valid = 1'b0;
        specificImpulse = '0;
        initialWeight = '0;
        propellantWeight = '0;
        burntime = '0;
        repeat (3) tick();
        chk("rst_vel", velocity, 0);
        chk("rst_wt", currentWeight, 0);
        chk("rst_sec", burnSecond, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ign", ignition_end, 0);
        chk("rst_perr", param_error, 0);
        reset = 1'b0;
        tick();
        chk("rst_ready", load_ready, 1);
        $display("reset: outputs cleared, load_ready=%0d", load_ready);

        for (int i = 0; i < 5; i++) run_vec(i);

        // Reset in the middle of a burn.
        begin
            int e, ign_seen, busy_seen;
            drive_vec(1);
            tick();
            load_valid = 1'b0;
            e = 0;
            while (burnSecond != 3 && e < 2*N + 4*T) begin
                tick();
                e++;
            end
            chk("mid_reached_tick3", burnSecond, 3);
            repeat (5) tick();
            reset = 1'b1;
            tick();
            reset = 1'b0;
            chk("mid_rst_vel", velocity, 0);
            chk("mid_rst_wt", currentWeight, 0);
            chk("mid_rst_sec", burnSecond, 0);
            chk("mid_rst_busy", busy, 0);
            ign_seen = 0;
            busy_seen = 0;
            for (int c = 0; c < 2*T; c++) begin
                if (ignition_end) ign_seen++;
                if (busy) busy_seen++;
                tick();
            end
            chk("mid_rst_no_ign", ign_seen, 0);
            chk("mid_rst_idle", busy_seen, 0);
            chk("mid_rst_ready", load_ready, 1);
            $display("mid-burn reset: velocity=%0d weight=%0d busy=%0d", velocity, currentWeight, busy);
        end

        run_vec(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got 0 expected 1");
        $fatal(1, "watchdog");
    end

endmodule
